// File: rtl/instruction_encoder_pkg.sv
// Shared definitions for the instruction encoder: opcode constants, buffer
// state encoding and the field-to-instruction packing helper.
package instruction_encoder_pkg;

    localparam logic [6:0] OP_R = 7'h33;
    localparam logic [6:0] OP_I = 7'h13;
    localparam logic [6:0] OP_U = 7'h37;
    localparam logic [6:0] OP_B = 7'h63;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FULL = 2'd2
    } enc_state_t;

    typedef struct packed {
        logic        legal;
        logic [31:0] instr;
    } enc_result_t;

    // Packs one field set into a 32-bit word and flags whether the opcode is
    // known and the immediate fits its format. An immediate fits when every
    // bit above the format's sign bit repeats that sign bit.
    function automatic enc_result_t encode_fields(
        input logic [6:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  funct3,
        input logic [6:0]  funct7,
        input logic [31:0] imm
    );
        enc_result_t res;
        res.legal = 1'b0;
        res.instr = 32'h0;
        case (op)
            OP_R: begin
                res.legal = 1'b1;
                res.instr = {funct7, rs2, rs1, funct3, rd, op};
            end
            OP_I: begin
                res.legal = (imm[31:11] == {21{imm[11]}});
                res.instr = {imm[11:0], rs1, funct3, rd, op};
            end
            OP_U: begin
                res.legal = (imm[31:19] == {13{imm[19]}});
                res.instr = {imm[19:0], rd, op};
            end
            OP_B: begin
                res.legal = !imm[0] && (imm[31:12] == {20{imm[12]}});
                res.instr = {imm[12], imm[10:5], rs2, rs1, funct3,
                             imm[4:1], imm[11], op};
            end
            default: begin
                res.legal = 1'b0;
                res.instr = 32'h0;
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/instruction_encoder_fifo.sv
// Synchronous FIFO holding encoded instruction/address pairs. The head entry
// is presented combinationally from the storage array.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/instruction_encoder.sv
// Instruction encoder: validates and packs register/immediate field sets into
// 32-bit instructions, tags each with a running word address and queues the
// pair for a downstream consumer.
//
// state   | meaning
// --------+------------------------------------------
// IDLE    | buffer empty, nothing to present
// BUSY    | 1..DEPTH-1 entries, both sides open
// FULL    | DEPTH entries, input side closed
module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
    parameter int          DEPTH     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [6:0]  op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] instruction_o,
    output logic [31:0] address_o,
    output logic        error_o,
    output logic [7:0]  error_count_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    enc_state_t  state_q;
    enc_state_t  state_d;
    enc_result_t enc;
    logic        accept;
    logic        push;
    logic        pop;
    logic [31:0] addr_q;
    logic [63:0] head;
    logic [63:0] last_q;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_next;
    logic        fifo_full;
    logic        fifo_empty;

    assign enc    = encode_fields(op_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i);
    assign accept = in_valid_i && in_ready_o;
    assign push   = accept && enc.legal && !fifo_full;
    assign pop    = out_valid_o && out_ready_i;

    sync_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data ({enc.instr, addr_q}),
        .rd_en   (pop),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign count_next = fifo_count + CW'(push) - CW'(pop);

    // State register tracking buffer occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake outputs decoded from the registered state; next state from
    // the occupancy this cycle's transfers will produce.
    always_comb begin
        state_d     = state_q;
        in_ready_o  = 1'b1;
        out_valid_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready_o  = 1'b1;
                out_valid_o = 1'b0;
            end
            ST_BUSY: begin
                in_ready_o  = 1'b1;
                out_valid_o = 1'b1;
            end
            ST_FULL: begin
                in_ready_o  = 1'b0;
                out_valid_o = 1'b1;
            end
            default: begin
                in_ready_o  = 1'b0;
                out_valid_o = 1'b0;
            end
        endcase
        if (count_next == '0) begin
            state_d = ST_IDLE;
        end else if (count_next == CW'(DEPTH)) begin
            state_d = ST_FULL;
        end else begin
            state_d = ST_BUSY;
        end
    end

    // Address counter and sticky error bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q        <= BASE_ADDR;
            error_o       <= 1'b0;
            error_count_o <= 8'h00;
        end else begin
            if (push) begin
                addr_q <= addr_q + 32'd4;
            end
            if (accept && !enc.legal) begin
                error_o <= 1'b1;
                if (error_count_o != 8'hFF) begin
                    error_count_o <= error_count_o + 8'd1;
                end
            end
        end
    end

    // Remember the most recent head so outputs hold steady once drained.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 64'h0;
        end else if (!fifo_empty) begin
            last_q <= head;
        end
    end

    assign instruction_o = fifo_empty ? last_q[63:32] : head[63:32];
    assign address_o     = fifo_empty ? last_q[31:0]  : head[31:0];

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0040_0000, word address given to the first encoded instruction after reset.
REQ-002 Parameter DEPTH, default 2, number of output buffer entries (power of two, at least 2).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid_i  input  1  field set on the inputs is valid this cycle.
REQ-006 in_ready_o  output  1  encoder can accept a field set this cycle.
REQ-007 op_i  input  7  opcode: 7'h13 I, 7'h37 U, 7'h63 B, 7'h33 R.
REQ-008 rd_i, rs1_i, rs2_i  input  5 each  register indices.
REQ-009 funct3_i  input  3; funct7_i  input  7  function fields.
REQ-010 imm_i  input  32  sign-extended immediate value, in the same form the immediate unit produces for each format.
REQ-011 out_valid_o  output  1  buffer head holds an encoded instruction.
REQ-012 out_ready_i  input  1  consumer takes the head this cycle.
REQ-013 instruction_o  output  32  encoded instruction at the buffer head.
REQ-014 address_o  output  32  memory address paired with instruction_o.
REQ-015 error_o  output  1  sticky error flag; error_count_o  output  8  count of rejected field sets, saturating.

Function
REQ-016 Transfer on input when in_valid_i and in_ready_o are both 1; transfer on output when out_valid_o and out_ready_i are both 1.
REQ-017 in_ready_o = 1 when buffer occupancy < DEPTH. It depends only on registered state.
REQ-018 R (7'h33): {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, op_i}; imm_i ignored.
REQ-019 I (7'h13): {imm_i[11:0], rs1_i, funct3_i, rd_i, op_i}; legal only if imm_i[31:11] are all equal.
REQ-020 U (7'h37): {imm_i[19:0], rd_i, op_i}; legal only if imm_i[31:19] are all equal. The immediate is the unshifted 20-bit field.
REQ-021 B (7'h63): {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11], op_i}.
REQ-022 B is legal only if imm_i[0] = 0 and imm_i[31:12] are all equal.
REQ-023 Any other opcode, or an immediate out of range, is illegal.
REQ-024 An illegal field set is still accepted, but it is not buffered and does not advance the address.
REQ-025 An illegal field set sets error_o and increments error_count_o, saturating at 255.
REQ-026 A legal accepted field set is written to the buffer tail together with the current address counter value.
REQ-027 After that write, the address counter advances by 4. It wraps modulo 2^32.
REQ-028 Latency: a field set accepted in cycle N has its instruction visible on instruction_o in cycle N+1 at the earliest. No combinational path exists from inputs to outputs.
REQ-029 Buffer order is FIFO. A simultaneous input and output transfer keeps occupancy unchanged, and is allowed when the buffer is full only if in_ready_o was already 1.
REQ-030 When the buffer is full, in_ready_o = 0 and no input is accepted; a pop that cycle reopens in_ready_o in the next cycle.
REQ-031 When the buffer is empty, out_valid_o = 0; instruction_o and address_o hold their last values and are don't-care.
REQ-032 State machine IDLE (empty) / BUSY (1..DEPTH-1 entries) / FULL (DEPTH entries).
REQ-033 State transitions follow occupancy only; the state is exposed to no port.

Reset
REQ-034 Reset sets: buffer empty, state IDLE, address counter = BASE_ADDR.
REQ-035 Reset sets: out_valid_o = 0, in_ready_o = 1, error_o = 0, error_count_o = 0, instruction_o = 0, address_o = 0.
REQ-036 Reset asserted mid-operation discards all buffered entries and overrides any simultaneous transfer.

Structure
REQ-037 Opcode constants (OP_R, OP_I, OP_U, OP_B) and state encodings belong in the shared package, also used by the immediate unit and the control unit.
REQ-038 The buffer is one sub-module, sync_fifo: parameterised width and depth, with count, full and empty outputs.

Verification
REQ-039 op=13, rd=5, rs1=6, funct3=0, imm=FFFF_FFFF -> instruction FFF3_0293 at address 0040_0000.
REQ-040 op=63, rs1=1, rs2=2, funct3=0, imm=FFFF_FFFC -> instruction FE20_8EE3; then op=37, rd=10, imm=0001_2345 -> 1234_5537 at the next address, 0040_0004.
REQ-041 B imm=0000_0003 (odd), then I imm=0000_0800 -> both dropped; error_o=1, error_count_o=2, address counter unchanged.
REQ-042 Hold out_ready_i=0 and push 3 legal field sets -> 2 accepted, in_ready_o=0; release out_ready_i -> outputs in order, addresses +0 and +4.
REQ-043 Push and pop simultaneously every cycle for 10 cycles -> occupancy constant at 1, no drops, addresses strictly +4 apart.
REQ-044 Assert reset with 2 entries buffered -> next cycle out_valid_o=0, in_ready_o=1; next instruction gets address 0040_0000.
